// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants, state encoding and word helpers for the SHA-256 message padder
package sha256_pkg;

    localparam int WORDS_PER_BLOCK = 16;
    localparam int IDX_W           = $clog2(WORDS_PER_BLOCK);

    localparam logic [IDX_W-1:0] LEN_HI_IDX = IDX_W'(14);
    localparam logic [31:0]      PAD_MARKER = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_PASS,
        ST_MARK,
        ST_ZERO,
        ST_LEN_HI,
        ST_LEN_LO
    } pad_state_e;

    // Keep the leading n bytes of d, put the 0x80 marker in byte n, clear the rest.
    function automatic logic [31:0] pad_partial(input logic [31:0] d, input logic [1:0] n);
        logic [31:0] w;
        case (n)
            2'd1:    w = {d[31:24], 8'h80, 16'h0000};
            2'd2:    w = {d[31:16], 8'h80, 8'h00};
            default: w = {d[31:8], 8'h80};
        endcase
        return w;
    endfunction

    // Once the word at slot idx has been emitted, zero-fill unless idx is the last
    // slot before the length words.
    function automatic pad_state_e after_pad_word(input logic [IDX_W-1:0] idx);
        return (idx == LEN_HI_IDX - IDX_W'(1)) ? ST_LEN_HI : ST_ZERO;
    endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - FIPS 180-4 padding of a byte message into a 32-bit word stream for a SHA-256 core
module sha256_msg_padder
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_last,
    input  logic [2:0]  s_bytes,
    output logic [31:0] input_data,
    output logic        input_valid,
    input  logic        input_ready,
    output logic        last_word
);

    pad_state_e       state, state_nxt;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] slot_idx;
    logic [63:0]      bit_cnt, bit_cnt_nxt;
    logic [31:0]      data_nxt;
    logic             last_nxt;
    logic             load;
    logic             slot_free;
    logic             accept;
    logic             xfer;

    assign xfer      = input_valid && input_ready;
    assign slot_free = !input_valid || input_ready;
    // A word loaded now lands one slot after the word draining this cycle.
    assign slot_idx  = input_valid ? word_idx + IDX_W'(1) : word_idx;
    assign s_ready   = rst && (state == ST_PASS) && slot_free;
    assign accept    = s_valid && s_ready;

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        data_nxt    = 32'h0;
        last_nxt    = 1'b0;
        load        = 1'b0;
        case (state)
            ST_PASS: begin
                if (accept) begin
                    load = 1'b1;
                    if (!s_last) begin
                        data_nxt    = s_data;
                        bit_cnt_nxt = bit_cnt + 64'd32;
                    end else if (s_bytes == 3'd0) begin
                        data_nxt  = PAD_MARKER;
                        state_nxt = after_pad_word(slot_idx);
                    end else if (s_bytes < 3'd4) begin
                        data_nxt    = pad_partial(s_data, s_bytes[1:0]);
                        bit_cnt_nxt = bit_cnt + {58'd0, s_bytes, 3'b000};
                        state_nxt   = after_pad_word(slot_idx);
                    end else begin
                        data_nxt    = s_data;
                        bit_cnt_nxt = bit_cnt + 64'd32;
                        state_nxt   = ST_MARK;
                    end
                end
            end
            ST_MARK: begin
                if (slot_free) begin
                    load      = 1'b1;
                    data_nxt  = PAD_MARKER;
                    state_nxt = after_pad_word(slot_idx);
                end
            end
            ST_ZERO: begin
                if (slot_free) begin
                    load      = 1'b1;
                    data_nxt  = 32'h0;
                    state_nxt = after_pad_word(slot_idx);
                end
            end
            ST_LEN_HI: begin
                if (slot_free) begin
                    load      = 1'b1;
                    data_nxt  = bit_cnt[63:32];
                    state_nxt = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (slot_free) begin
                    load        = 1'b1;
                    data_nxt    = bit_cnt[31:0];
                    last_nxt    = 1'b1;
                    bit_cnt_nxt = 64'd0;
                    state_nxt   = ST_PASS;
                end
            end
            default: state_nxt = ST_PASS;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_PASS;
            word_idx    <= '0;
            bit_cnt     <= 64'd0;
            input_valid <= 1'b0;
            input_data  <= 32'h0;
            last_word   <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            if (xfer) begin
                word_idx <= word_idx + IDX_W'(1);
            end
            if (load) begin
                input_valid <= 1'b1;
                input_data  <= data_nxt;
                last_word   <= last_nxt;
            end else if (xfer) begin
                input_valid <= 1'b0;
                last_word   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - directed table-driven bench for sha256_msg_padder
module tb_sha256_msg_padder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [2:0]  s_bytes;
    logic [31:0] input_data;
    logic        input_valid;
    logic        input_ready;
    logic        last_word;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] got_q[$];

    typedef struct {
        int          n_full;
        logic [2:0]  nbytes;
        logic [31:0] last_data;
        int          n_words;
        int          marker_idx;
        logic [31:0] marker_word;
        logic [31:0] len_lo;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    sha256_msg_padder dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_last      (s_last),
        .s_bytes     (s_bytes),
        .input_data  (input_data),
        .input_valid (input_valid),
        .input_ready (input_ready),
        .last_word   (last_word)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] exp_word(input vec_t v, input int i);
        if (i == v.n_words - 1) return v.len_lo;
        if (i == v.marker_idx) return v.marker_word;
        if (i < v.n_full) return pat(i);
        if (i == v.n_full && v.nbytes >= 3'd4) return v.last_data;
        return 32'h0;
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int w;
        w       = 0;
        s_data  = d;
        s_last  = last;
        s_bytes = nb;
        s_valid = 1'b1;
        do begin
            @(negedge clk);
            w++;
        end while (!s_ready && w < 300);
        if (!s_ready) check("s_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_bytes = 3'd0;
        s_data  = 32'h0;
    endtask

    task automatic send_msg(input vec_t v);
        for (int i = 0; i < v.n_full; i++) begin
            send_beat(pat(i), 1'b0, 3'($urandom_range(0, 7)));
        end
        send_beat(v.last_data, 1'b1, v.nbytes);
    endtask

    task automatic collect(input int budget, input bit stall);
        logic [32:0] held;
        bit          holding;
        bit          done;
        holding = 1'b0;
        done    = 1'b0;
        held    = '0;
        got_q.delete();
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (holding) check("stall_hold", 64'({last_word, input_data}), 64'(held));
            holding = 1'b0;
            if (input_valid && input_ready) begin
                got_q.push_back({last_word, input_data});
                if (last_word) done = 1'b1;
            end else if (input_valid) begin
                holding = 1'b1;
                held    = {last_word, input_data};
            end
            @(posedge clk);
            #2;
            input_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (!done) check("collect_timeout", 64'd0, 64'd1);
        input_ready = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int k, input bit stall);
        fork
            send_msg(v);
            collect(600, stall);
        join
        check($sformatf("v%0d_count", k), 64'(got_q.size()), 64'(v.n_words));
        for (int i = 0; i < got_q.size() && i < v.n_words; i++) begin
            check($sformatf("v%0d_word%0d", k, i), 64'(got_q[i]),
                  64'({(i == v.n_words - 1), exp_word(v, i)}));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_input_valid"}, 64'(input_valid), 64'd0);
        check({tag, "_input_data"},  64'(input_data),  64'd0);
        check({tag, "_last_word"},   64'(last_word),   64'd0);
        check({tag, "_s_ready"},     64'(s_ready),     64'd0);
    endtask

    initial begin
        // n_full, s_bytes, last beat data, words out, marker index, marker word, length low word
        vecs[0]  = '{0,  3'd3, 32'h61626300, 16, 0,  32'h61626380, 32'h0000_0018};
        vecs[1]  = '{0,  3'd0, 32'h0,        16, 0,  32'h8000_0000, 32'h0000_0000};
        vecs[2]  = '{13, 3'd3, 32'hAABBCCDD, 16, 13, 32'hAABBCC80, 32'h0000_01B8};
        vecs[3]  = '{13, 3'd4, 32'h11223344, 32, 14, 32'h8000_0000, 32'h0000_01C0};
        vecs[4]  = '{0,  3'd1, 32'hDEADBEEF, 16, 0,  32'hDE80_0000, 32'h0000_0008};
        vecs[5]  = '{1,  3'd2, 32'h12345678, 16, 1,  32'h1234_8000, 32'h0000_0030};
        vecs[6]  = '{14, 3'd0, 32'h0,        32, 14, 32'h8000_0000, 32'h0000_01C0};
        vecs[7]  = '{15, 3'd2, 32'hCAFEBABE, 32, 15, 32'hCAFE_8000, 32'h0000_01F0};
        vecs[8]  = '{0,  3'd6, 32'h01020304, 16, 1,  32'h8000_0000, 32'h0000_0020};
        vecs[9]  = '{15, 3'd4, 32'h0F0E0D0C, 32, 16, 32'h8000_0000, 32'h0000_0200};
        vecs[10] = '{15, 3'd0, 32'h0,        32, 15, 32'h8000_0000, 32'h0000_01E0};

        rst         = 1'b0;
        s_data      = 32'h0;
        s_valid     = 1'b0;
        s_last      = 1'b0;
        s_bytes     = 3'd0;
        input_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int k = 0; k < 11; k++) begin
            run_vec(vecs[k], k, 1'b0);
        end

        run_vec(vecs[0], 100, 1'b1);
        run_vec(vecs[3], 103, 1'b1);

        for (int k = 0; k < 5; k++) begin
            send_beat(pat(k), 1'b0, 3'd4);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("mid_rst_hold");
        @(negedge clk);
        rst = 1'b1;
        run_vec(vecs[0], 200, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
